// File: rtl/dma_buf_pkg.sv
// Shared types and constants for the DMA burst buffer.
// Burst FSM state encoding and read-during-write mode selectors.
package dma_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRBURST,
        RDBURST,
        DONE
    } dma_state_e;

    localparam bit MODE_WRITE_FIRST = 1'b0;
    localparam bit MODE_READ_FIRST  = 1'b1;

endpackage

// File: rtl/dma_burst_buffer_if.sv
// Bus bundle for the DMA burst buffer: CPU port A, burst control, streams.
// slave = buffer side, master = CPU/DMA side.
interface dma_burst_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                      weA;
    logic [DATA_WIDTH/8-1:0]   byteEnA;
    logic [ADDR_WIDTH-1:0]     addressA;
    logic [DATA_WIDTH-1:0]     dataInA;
    logic [DATA_WIDTH-1:0]     dataOutA;
    logic                      burstStart;
    logic                      burstWrite;
    logic [ADDR_WIDTH-1:0]     burstAddress;
    logic [ADDR_WIDTH:0]       burstLength;
    logic                      busy;
    logic                      burstDone;
    logic [DATA_WIDTH-1:0]     streamInData;
    logic                      streamInValid;
    logic                      streamInReady;
    logic [DATA_WIDTH-1:0]     streamOutData;
    logic                      streamOutValid;
    logic                      streamOutReady;

    modport slave (
        input  weA, byteEnA, addressA, dataInA,
        input  burstStart, burstWrite, burstAddress, burstLength,
        input  streamInData, streamInValid, streamOutReady,
        output dataOutA, busy, burstDone,
        output streamInReady, streamOutData, streamOutValid
    );

    modport master (
        output weA, byteEnA, addressA, dataInA,
        output burstStart, burstWrite, burstAddress, burstLength,
        output streamInData, streamInValid, streamOutReady,
        input  dataOutA, busy, burstDone,
        input  streamInReady, streamOutData, streamOutValid
    );
endinterface

// File: rtl/dma_buf_skid.sv
// Two-entry valid/ready skid buffer for the read stream.
// Outputs come straight from flops; in_ready depends only on occupancy.
module dma_buf_skid #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        push   = in_valid && (cnt_q != 2'd2);
        pop    = (cnt_q != 2'd0) && out_ready;
        if (push && pop) begin
            if (cnt_q == 2'd1) ent0_d = in_data;
            else begin
                ent0_d = ent1_q;
                ent1_d = in_data;
            end
        end else if (pop) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end else if (push) begin
            if (cnt_q == 2'd0) ent0_d = in_data;
            else ent1_d = in_data;
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q;
endmodule

// File: rtl/dma_burst_buffer.sv
// Dual-port DMA buffer: CPU byte-write port A plus burst stream engine on B.
// Define DMA_BUF_COLLISION_FLAG_EN to add the sticky A/B write-collision output.
module dma_burst_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int READ_FIRST = 0
) (
    input  logic               clock,
    input  logic               reset,
`ifdef DMA_BUF_COLLISION_FLAG_EN
    output logic               collision,
`endif
    dma_burst_buffer_if.slave  bus
);
    import dma_buf_pkg::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam bit RF    = (READ_FIRST != 0) ? MODE_READ_FIRST : MODE_WRITE_FIRST;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dma_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LW-1:0]         cnt_q;
    logic [LW-1:0]         out_cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
    logic [DATA_WIDTH-1:0] rd_new;
    logic                  b_we, a_hit, start_ok;
    logic                  sk_push, sk_in_ready, sk_out_valid, beat_out;
    logic [DATA_WIDTH-1:0] sk_out_data;

    always_comb begin
        b_we     = (state_q == WRBURST) && in_ready_q && bus.streamInValid;
        a_hit    = bus.weA && b_we && (bus.addressA == addr_q);
        start_ok = (state_q == IDLE) && bus.burstStart;
        sk_push  = (state_q == RDBURST) && (cnt_q != '0) && sk_in_ready;
        beat_out = sk_out_valid && bus.streamOutReady;
    end

    // Port A read sees the word as it will be after this cycle's writes
    always_comb begin
        rd_new = mem[bus.addressA];
        if (b_we && !a_hit && (addr_q == bus.addressA))
            rd_new = bus.streamInData;
        if (bus.weA)
            for (int i = 0; i < NB; i++)
                if (bus.byteEnA[i])
                    rd_new[8*i +: 8] = bus.dataInA[8*i +: 8];
        dout_a_d = (RF == MODE_READ_FIRST) ? mem[bus.addressA] : rd_new;
    end

    always_ff @(posedge clock) begin
        if (b_we && !a_hit)
            mem[addr_q] <= bus.streamInData;
        if (bus.weA)
            for (int i = 0; i < NB; i++)
                if (bus.byteEnA[i])
                    mem[bus.addressA][8*i +: 8] <= bus.dataInA[8*i +: 8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            out_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            dout_a_q   <= '0;
        end else begin
            dout_a_q <= dout_a_d;
            done_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        addr_q    <= bus.burstAddress;
                        cnt_q     <= bus.burstLength;
                        out_cnt_q <= bus.burstLength;
                        busy_q    <= 1'b1;
                        if (bus.burstLength == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (bus.burstWrite) begin
                            state_q    <= WRBURST;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= RDBURST;
                        end
                    end
                end
                WRBURST: begin
                    if (b_we) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == LW'(1)) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                RDBURST: begin
                    if (sk_push) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                    if (beat_out) begin
                        out_cnt_q <= out_cnt_q - 1'b1;
                        if (out_cnt_q == LW'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dma_buf_skid #(.W(DATA_WIDTH)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (sk_push),
        .in_ready  (sk_in_ready),
        .in_data   (mem[addr_q]),
        .out_valid (sk_out_valid),
        .out_ready (bus.streamOutReady),
        .out_data  (sk_out_data)
    );

`ifdef DMA_BUF_COLLISION_FLAG_EN
    logic coll_q, coll_d;

    always_comb begin
        coll_d = coll_q;
        if (start_ok) coll_d = 1'b0;
        if (a_hit) coll_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) coll_q <= 1'b0;
        else coll_q <= coll_d;
    end

    assign collision = coll_q;
`endif

    assign bus.dataOutA       = dout_a_q;
    assign bus.busy           = busy_q;
    assign bus.burstDone      = done_q;
    assign bus.streamInReady  = in_ready_q;
    assign bus.streamOutValid = sk_out_valid;
    assign bus.streamOutData  = sk_out_data;
endmodule
